bullet_ctrl: RTL

- Downstream consumer of the tank movement stage's ShootBullet, tank position and heading (sin/cos of current Angle).
- Owns a fixed pool of bullets: spawns one per fire press, moves every active bullet once per frame and reflects it off the screen edges.
- Retires each bullet when its lifetime expires.
- Outputs per-bullet position and active flags to the sprite/colour mapper and the hit-detection logic.

---
 rtl/bullet_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: fixed pool of bullets fed by the tank movement stage.
// Spawns one bullet per fire press into the lowest free slot, moves every
// live bullet once per frame, reflects it off the screen edges and retires
// it after a fixed number of frames.
`timescale 1ns/1ps

module bullet_ctrl #(
  parameter int         NUM_BULLETS = 5,
  parameter logic [7:0] BULLET_STEP = 8'h08,
  parameter logic [9:0] LIFETIME    = 10'd120,
  parameter logic [5:0] COOLDOWN    = 6'd10,
  parameter logic [9:0] X_MIN       = 10'd0,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MIN       = 10'd0,
  parameter logic [9:0] Y_MAX       = 10'd479
) (
  input  logic                          frame_clk,
  input  logic                          Reset_n,
  input  logic                          ShootBullet,
  input  logic [9:0]                    TankX,
  input  logic [9:0]                    TankY,
  input  logic [7:0]                    sin,
  input  logic [7:0]                    cos,
  output logic [10*NUM_BULLETS-1:0]     BulletX,
  output logic [10*NUM_BULLETS-1:0]     BulletY,
  output logic [NUM_BULLETS-1:0]        BulletActive,
  output logic                          FireAck
);

  // One axis of motion after a frame: new position and possibly reflected velocity.
  typedef struct packed {
    logic [9:0] pos;
    logic [9:0] vel;
  } axis_t;

  // Per-slot state, packed so slot i sits at bits [10i+9:10i] like the outputs.
  logic [NUM_BULLETS-1:0][9:0] pos_x;
  logic [NUM_BULLETS-1:0][9:0] pos_y;
  logic [NUM_BULLETS-1:0][9:0] vel_x;
  logic [NUM_BULLETS-1:0][9:0] vel_y;
  logic [NUM_BULLETS-1:0][9:0] life;
  logic [NUM_BULLETS-1:0]      active;

  // Fire control state.
  logic [5:0] cooldown;
  logic       shoot_prev;
  logic       primed;

  // Combinational decisions for the current frame.
  logic                        fire_req;
  logic                        fire_accept;
  logic                        pool_has_free;
  logic [NUM_BULLETS-1:0]      spawn_onehot;
  logic [13:0]                 prod_x;
  logic [13:0]                 prod_y;
  logic [6:0]                  mag_x;
  logic [6:0]                  mag_y;
  logic [9:0]                  spawn_vx;
  logic [9:0]                  spawn_vy;
  axis_t [NUM_BULLETS-1:0]     step_x;
  axis_t [NUM_BULLETS-1:0]     step_y;

  // Advance one axis by its velocity in 11-bit signed arithmetic and reflect
  // off [lo, hi], clamping the position to the edge it crossed.
  function automatic axis_t axis_step(input logic [9:0] pos,
                                      input logic [9:0] vel,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
    logic signed [10:0] nxt;
    axis_t              r;
    nxt   = $signed({1'b0, pos}) + $signed({vel[9], vel});
    r.pos = nxt[9:0];
    r.vel = vel;
    if (nxt < $signed({1'b0, lo})) begin
      r.pos = lo;
      r.vel = 10'd0 - vel;
    end else if (nxt > $signed({1'b0, hi})) begin
      r.pos = hi;
      r.vel = 10'd0 - vel;
    end
    return r;
  endfunction

  // Rising edge of the fire key; ignored on the first edge after reset so a
  // key held through reset must be released and pressed again.
  assign fire_req    = ShootBullet & ~shoot_prev & primed;
  assign fire_accept = fire_req && (cooldown == 6'd0) && pool_has_free;

  // Pick the lowest-index slot that is free at the start of this frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    spawn_onehot  = '0;
    pool_has_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !pool_has_free) begin
        spawn_onehot[i] = 1'b1;
        pool_has_free   = 1'b1;
      end
    end
  end

  // Launch velocity from the current heading; magnitude is step*trig/128.
  always_comb begin
    prod_x   = {7'd0, BULLET_STEP[6:0]} * {7'd0, cos[6:0]};
    prod_y   = {7'd0, BULLET_STEP[6:0]} * {7'd0, sin[6:0]};
    mag_x    = prod_x[13:7];
    mag_y    = prod_y[13:7];
    // Negative cosine points left.
    spawn_vx = cos[7] ? (10'd0 - {3'd0, mag_x}) : {3'd0, mag_x};
    // Screen Y grows downward, so a positive sine moves the bullet up.
    spawn_vy = sin[7] ? {3'd0, mag_y} : (10'd0 - {3'd0, mag_y});
  end

  // Candidate next position/velocity of every slot, with edge reflection.
  always_comb begin
    step_x = '0;
    step_y = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      step_x[i] = axis_step(pos_x[i], vel_x[i], X_MIN, X_MAX);
      step_y[i] = axis_step(pos_y[i], vel_y[i], Y_MIN, Y_MAX);
    end
  end

  // Key edge detector, post-reset priming and the spawn acknowledge pulse.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shoot_prev <= 1'b0;
      primed     <= 1'b0;
      FireAck    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      shoot_prev <= ShootBullet;
      primed     <= 1'b1;
      FireAck    <= fire_accept;
    end
  end

  // Fire cooldown: reload on an accepted fire, otherwise count down to zero.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cooldown <= 6'd0;
    end else if (fire_accept) begin
      cooldown <= COOLDOWN;
    end else if (cooldown != 6'd0) begin
      cooldown <= cooldown - 6'd1;
    end
  end

  // Slot array: spawn into the chosen slot, otherwise move and age live slots.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the slot state is a handful of flops, not a RAM, so clearing it
      // in reset is cheap and keeps the outputs defined straight away.
      pos_x  <= '0;
      pos_y  <= '0;
      vel_x  <= '0;
      vel_y  <= '0;
      life   <= '0;
      active <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (fire_accept && spawn_onehot[i]) begin
          pos_x[i]  <= TankX;
          pos_y[i]  <= TankY;
          vel_x[i]  <= spawn_vx;
          vel_y[i]  <= spawn_vy;
          life[i]   <= LIFETIME;
          active[i] <= 1'b1;
        end else if (active[i]) begin
          if (life[i] == 10'd1) begin
            // Last frame: retire in place, position left as it was.
            active[i] <= 1'b0;
            life[i]   <= 10'd0;
          end else begin
            pos_x[i] <= step_x[i].pos;
            vel_x[i] <= step_x[i].vel;
            pos_y[i] <= step_y[i].pos;
            vel_y[i] <= step_y[i].vel;
            life[i]  <= life[i] - 10'd1;
          end
        end
      end
    end
  end

  // Packed slot arrays already match the flattened output layout.
  assign BulletX      = pos_x;
  assign BulletY      = pos_y;
  assign BulletActive = active;

endmodule
